// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: registered one-hot and binary grant, held until done_i or withdrawal.
// Optional macro ARB_TIMEOUT_EN revokes a grant after MAX_HOLD cycles and pulses timeout_o.
module rr_onehot_arbiter #(
    parameter int NUM_REQ  = 16,
    parameter int ID_W     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_valid_o,
    output logic               timeout_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt, id_nxt, win;
    logic               valid_nxt, found, natural_rel, rel, expire;
    logic [NUM_REQ-1:0] gnt_nxt;

    if (ID_W != $clog2(NUM_REQ) || MAX_HOLD < 2) begin : g_param_check
        $error("rr_onehot_arbiter: inconsistent parameters");
    end

    // Scan descending and overwrite so the first set bit at or after start wins.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] cand,
                                           input logic [ID_W-1:0]    start);
        logic [ID_W:0] res;
        int            k;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (cand[k[ID_W-1:0]]) res = {1'b1, k[ID_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold;
    logic              tout_nxt;

    assign expire   = (state == BUSY) && (hold == HOLD_W'(MAX_HOLD - 1));
    assign tout_nxt = expire && !natural_rel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            timeout_o <= 1'b0;
        end else begin
            hold      <= (state == BUSY && !rel) ? hold + HOLD_W'(1) : '0;
            timeout_o <= tout_nxt;
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        id_nxt       = gnt_id_o;
        valid_nxt    = gnt_valid_o;
        {found, win} = pick(req_i, ptr);
        natural_rel  = done_i || !req_i[gnt_id_o];
        rel          = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    id_nxt    = win;
                    valid_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                rel = natural_rel || expire;
                if (rel) begin
                    // The released owner is excluded only for this handoff.
                    ptr_nxt      = next_id(gnt_id_o);
                    {found, win} = pick(req_i & ~(NUM_REQ'(1) << gnt_id_o), ptr_nxt);
                    if (found) begin
                        id_nxt    = win;
                        valid_nxt = 1'b1;
                    end else begin
                        id_nxt    = '0;
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_nxt = valid_nxt ? (NUM_REQ'(1) << id_nxt) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            gnt_valid_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gnt_o       <= gnt_nxt;
            gnt_id_o    <= id_nxt;
            gnt_valid_o <= valid_nxt;
        end
    end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios plus random traffic against an owner/pointer model.
module tb_rr_onehot_arbiter;
    localparam int N        = 16;
    localparam int IW       = 4;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          done = 1'b0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          gnt_valid;
    logic          timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: current owner (-1 = none), priority pointer, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tout  = 1'b0;

    rr_onehot_arbiter #(.NUM_REQ(N), .ID_W(IW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .done_i(done),
        .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_valid_o(gnt_valid), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int scan(input logic [N-1:0] r, input int start, input int excl);
        for (int i = 0; i < N; i++) begin
            int k = (start + i) % N;
            if (k != excl && r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic d);
        bit nat, exp_t;
        if (m_owner < 0) begin
            m_tout  = 1'b0;
            m_owner = scan(r, m_ptr, -1);
            m_hold  = 0;
        end else begin
            nat   = d || !r[m_owner];
            exp_t = TO_EN && (m_hold == MAX_HOLD - 1);
            if (nat || exp_t) begin
                m_tout  = exp_t && !nat;
                m_ptr   = (m_owner + 1) % N;
                m_owner = scan(r, m_ptr, m_owner);
                m_hold  = 0;
            end else begin
                m_tout = 1'b0;
                m_hold++;
            end
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("id", 32'(gnt_id), (m_owner >= 0) ? m_owner : 0);
        chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("timeout", 32'(timeout), 32'(m_tout));
        chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_all();
    endtask

    // Asserts reset between edges, confirms outputs clear without an edge, then releases.
    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_tout  = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        apply_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Single request, then done with request dropped.
        cyc(16'h0008, 1'b0);
        chk("single_gnt", 32'(gnt), 32'h0008);
        chk("single_id", 32'(gnt_id), 32'd3);
        cyc(16'h0008, 1'b0);
        cyc(16'h0000, 1'b1);
        chk("single_idle", 32'(gnt_valid), 32'd0);
        cyc(16'h0000, 1'b1);

        // Fairness between id 0 and id 15 with pointer wrap.
        apply_reset();
        cyc(16'h8001, 1'b0);
        chk("rr_0a", 32'(gnt_id), 32'd0);
        cyc(16'h8001, 1'b1);
        chk("rr_15a", 32'(gnt_id), 32'd15);
        cyc(16'h8001, 1'b0);
        cyc(16'h8001, 1'b1);
        chk("rr_0b", 32'(gnt_id), 32'd0);
        cyc(16'h8001, 1'b0);
        cyc(16'h8001, 1'b1);
        chk("rr_15b", 32'(gnt_id), 32'd15);

        // Back-to-back handoff 1 -> 2 -> 4 -> 1.
        apply_reset();
        cyc(16'h0016, 1'b0);
        chk("b2b_1", 32'(gnt_id), 32'd1);
        cyc(16'h0016, 1'b1);
        chk("b2b_2", 32'(gnt_id), 32'd2);
        chk("b2b_v", 32'(gnt_valid), 32'd1);
        cyc(16'h0016, 1'b1);
        chk("b2b_4", 32'(gnt_id), 32'd4);
        cyc(16'h0016, 1'b1);
        chk("b2b_1w", 32'(gnt_id), 32'd1);

        // Withdrawal by owner 5 hands over to 9.
        apply_reset();
        cyc(16'h0220, 1'b0);
        chk("wd_5", 32'(gnt_id), 32'd5);
        cyc(16'h0200, 1'b0);
        chk("wd_9", 32'(gnt_id), 32'd9);

        // Asynchronous reset while id 7 holds the grant.
        apply_reset();
        cyc(16'h0080, 1'b0);
        cyc(16'h0080, 1'b0);
        chk("mid_7", 32'(gnt_id), 32'd7);
        #2;
        apply_reset();
        chk("mid_clr", 32'(gnt_valid), 32'd0);
        cyc(16'h00FF, 1'b0);
        chk("mid_0", 32'(gnt_id), 32'd0);

        // Long hold of id 0 with id 1 waiting.
        apply_reset();
`ifdef ARB_TIMEOUT_EN
        repeat (9) cyc(16'h0003, 1'b0);
        chk("to_id", 32'(gnt_id), 32'd1);
        chk("to_pulse", 32'(timeout), 32'd1);
        cyc(16'h0003, 1'b0);
        chk("to_end", 32'(timeout), 32'd0);
`else
        repeat (50) cyc(16'h0003, 1'b0);
        chk("hold_id", 32'(gnt_id), 32'd0);
        chk("hold_to", 32'(timeout), 32'd0);
`endif

        // Random traffic: sparse requests and occasional done.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            r = N'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) r = '0;
            cyc(r, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
